// File: rtl/apu_serial_pkg.sv
// Shared on-wire definitions for the APU register serial link.
// Used by both the transmit encoder and the receive decoder.
package apu_serial_pkg;

    localparam int FRAME_WIDTH = 10;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic [FRAME_WIDTH-1:0] IDLE_PATTERN = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOW_FRAME,
        LOW_GAP,
        HIGH_FRAME,
        HIGH_GAP
    } enc_state_e;

    // Payload byte: upper nibble is the 4-bit address {index, half}
    function automatic logic [7:0] compose_payload(
        input logic [2:0] index,
        input logic       half,
        input logic [3:0] nibble
    );
        return {index, half, nibble};
    endfunction

endpackage

// File: rtl/encoder_frame_tx.sv
// Single-frame serialiser: start bit, 8 payload bits LSB first,
// stop bit, then GAP_BITS idle bits, each held CLKS_PER_BIT cycles.
module frame_tx
    import apu_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 1
) (
    input  logic       sck,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] payload,
    output logic       sdo,
    output logic       frame_done,
    output logic       gap_done
);

    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BMAX = (GAP_BITS > FRAME_WIDTH) ? GAP_BITS : FRAME_WIDTH;
    localparam int BW = $clog2(BMAX + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_WIDTH - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);

    logic          active;
    logic          in_gap;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [8:0]    shift;
    logic          bit_end;

    assign bit_end    = active && (div_cnt == DIV_LAST);
    assign frame_done = bit_end && !in_gap && (bit_cnt == FRAME_LAST);
    assign gap_done   = bit_end && in_gap && (bit_cnt == GAP_LAST);

    // shift holds the bits still to go after the current one;
    // ones shifted in behind the stop bit keep the line high
    always_ff @(posedge sck) begin
        if (rst) begin
            active  <= 1'b0;
            in_gap  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shift   <= '1;
            sdo     <= IDLE_PATTERN[0];
        end else if (load) begin
            active  <= 1'b1;
            in_gap  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shift   <= {STOP_BIT, payload};
            sdo     <= START_BIT;
        end else if (bit_end) begin
            div_cnt <= '0;
            if (frame_done) begin
                in_gap  <= 1'b1;
                bit_cnt <= '0;
                sdo     <= IDLE_PATTERN[0];
            end else if (gap_done) begin
                active  <= 1'b0;
                in_gap  <= 1'b0;
                bit_cnt <= '0;
                sdo     <= IDLE_PATTERN[0];
            end else if (in_gap) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sdo     <= shift[0];
                shift   <= {1'b1, shift[8:1]};
            end
        end else if (active) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/encoder.sv
// APU register write encoder: one accepted write becomes a low-nibble
// frame followed by a high-nibble frame on the serial line.
module encoder
    import apu_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 1
) (
    input  logic       sck,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_index,
    input  logic [7:0] in_data,
    output logic       sdo,
    output logic       busy
);

    enc_state_e state;
    enc_state_e state_d;

    logic [2:0] idx_q;
    logic [3:0] hi_q;
    logic       accept;
    logic       load;
    logic [7:0] payload;
    logic       frame_done;
    logic       gap_done;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // The high frame is loaded on the same edge the low gap ends,
    // so no extra idle bit appears between the two frames
    always_comb begin
        state_d = state;
        load    = 1'b0;
        payload = compose_payload(in_index, 1'b0, in_data[3:0]);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = LOW_FRAME;
                end
            end
            LOW_FRAME: begin
                if (frame_done) state_d = LOW_GAP;
            end
            LOW_GAP: begin
                if (gap_done) begin
                    load    = 1'b1;
                    payload = compose_payload(idx_q, 1'b1, hi_q);
                    state_d = HIGH_FRAME;
                end
            end
            HIGH_FRAME: begin
                if (frame_done) state_d = HIGH_GAP;
            end
            HIGH_GAP: begin
                if (gap_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state <= IDLE;
            idx_q <= '0;
            hi_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                idx_q <= in_index;
                hi_q  <= in_data[7:4];
            end
        end
    end

    frame_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .GAP_BITS    (GAP_BITS)
    ) u_frame_tx (
        .sck       (sck),
        .rst       (rst),
        .load      (load),
        .payload   (payload),
        .sdo       (sdo),
        .frame_done(frame_done),
        .gap_done  (gap_done)
    );

endmodule
